// File: rtl/fifo_gen_pkg.sv
// Shared encodings for the FIFO write generator: host-visible mode codes and FSM states.
package fifo_gen_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_CONT   = 2'b01,
        MODE_REFILL = 2'b10,
        MODE_BURST  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single level signal crossing into the local clock domain.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_gen.sv
// Test-pattern write generator for a FIFO (continuous, refill-on-empty and burst modes).
// Define FIFO_WR_GEN_ERR_EN to add the sticky ovf_err output (write while full).
module fifo_wr_gen
    import fifo_gen_pkg::*;
#(
    parameter int              DW          = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [DW-1:0]   MAX_VAL     = {{(DW-1){1'b1}}, 1'b0},
    parameter int              BURST_LEN   = 16
) (
    input  logic          wr_clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic          start,
    input  logic          wr_rst_busy,
    input  logic          empty,
    input  logic          almost_full,
    input  logic          full,
    output logic          fifo_wr_en,
    output logic [DW-1:0] fifo_wr_data,
    output logic          busy,
    output logic          burst_done
`ifdef FIFO_WR_GEN_ERR_EN
    ,
    output logic          ovf_err
`endif
);

    localparam int            CW       = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

    state_e        state_q;
    mode_e         mode_q;
    logic [CW-1:0] cnt_q;
    logic          wr_en_q;
    logic [DW-1:0] data_q;
    logic          burst_done_q;
    logic          done_pend_q;
    logic          ready_q;
    logic          empty_s;
    logic          launch;
    logic          resume;
    logic [DW-1:0] data_inc;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_empty_sync (
        .clk_i  (wr_clk),
        .rst_ni (rst),
        .d_i    (empty),
        .q_o    (empty_s)
    );

    // ready_q holds off launch for one cycle after reset release
    always_comb begin
        launch = 1'b0;
        if (ready_q && enable) begin
            case (mode_e'(mode))
                MODE_CONT:   launch = 1'b1;
                MODE_REFILL: launch = empty_s;
                MODE_BURST:  launch = start;
                default:     launch = 1'b0;
            endcase
        end
    end

    assign resume   = !almost_full && ((mode_q != MODE_REFILL) || empty_s);
    assign data_inc = (data_q == MAX_VAL) ? '0 : data_q + 1'b1;

    always_ff @(posedge wr_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_OFF;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            data_q       <= '0;
            burst_done_q <= 1'b0;
            done_pend_q  <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            ready_q      <= 1'b1;
            wr_en_q      <= 1'b0;
            done_pend_q  <= 1'b0;
            burst_done_q <= done_pend_q;
            if (wr_en_q) begin
                data_q <= data_inc;
            end
            // FIFO write-side reset freezes the sequencer in place
            if (!wr_rst_busy) begin
                case (state_q)
                    ST_IDLE: begin
                        if (launch) begin
                            mode_q  <= mode_e'(mode);
                            state_q <= ST_WRITE;
                            cnt_q   <= '0;
                            if (!almost_full) begin
                                wr_en_q <= 1'b1;
                                cnt_q   <= CW'(1);
                                if (mode_e'(mode) == MODE_BURST && BURST_LEN == 1) begin
                                    state_q     <= ST_IDLE;
                                    done_pend_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (!enable) begin
                            state_q      <= ST_IDLE;
                            burst_done_q <= done_pend_q || (mode_q == MODE_BURST);
                        end else if (almost_full) begin
                            state_q <= ST_WAIT;
                        end else begin
                            wr_en_q <= 1'b1;
                            if (mode_q == MODE_BURST) begin
                                cnt_q <= cnt_q + 1'b1;
                                if (cnt_q == LAST_CNT) begin
                                    state_q     <= ST_IDLE;
                                    done_pend_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (!enable) begin
                            state_q      <= ST_IDLE;
                            burst_done_q <= done_pend_q || (mode_q == MODE_BURST);
                        end else if (resume) begin
                            state_q <= ST_WRITE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = data_q;
    assign busy         = (state_q != ST_IDLE);
    assign burst_done   = burst_done_q;

`ifdef FIFO_WR_GEN_ERR_EN
    logic ovf_q;

    always_ff @(posedge wr_clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (full && wr_en_q) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
`else
    logic unused_full;
    assign unused_full = full;
`endif

endmodule

// File: tb/tb_fifo_wr_gen.sv
// Directed bench for fifo_wr_gen: expected write data queued by the stimulus, popped by a write monitor.
module tb_fifo_wr_gen;

    logic       wr_clk;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic       start;
    logic       wr_rst_busy;
    logic       empty;
    logic       almost_full;
    logic       full;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       busy;
    logic       burst_done;
`ifdef FIFO_WR_GEN_ERR_EN
    logic       ovf_err;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_d = 8'd0;

    fifo_wr_gen #(
        .DW          (8),
        .SYNC_STAGES (2),
        .BURST_LEN   (4)
    ) dut (
        .wr_clk       (wr_clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .start        (start),
        .wr_rst_busy  (wr_rst_busy),
        .empty        (empty),
        .almost_full  (almost_full),
        .full         (full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy),
        .burst_done   (burst_done)
`ifdef FIFO_WR_GEN_ERR_EN
        ,
        .ovf_err      (ovf_err)
`endif
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back(exp_d);
            exp_d = (exp_d == 8'd254) ? 8'd0 : exp_d + 8'd1;
        end
    endtask

    // Every observed write must match the next queued expectation
    always @(negedge wr_clk) begin
        if (fifo_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {31'b0, fifo_wr_en}, 32'd0);
            end else begin
                $display("write data=%0d", fifo_wr_data);
                check("wr_data", {24'b0, fifo_wr_data}, {24'b0, sb.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b0; enable = 1'b1; mode = 2'b01; start = 1'b0;
        wr_rst_busy = 1'b0; empty = 1'b0; almost_full = 1'b0; full = 1'b0;

        // reset state
        repeat (3) tick();
        check("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
        check("rst_data", {24'b0, fifo_wr_data}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_burst_done", {31'b0, burst_done}, 32'd0);

        // CONT from reset: 0..254 then wrap
        push_n(258);
        rst = 1'b1;
        tick(); check("cont_rel_wait", {31'b0, fifo_wr_en}, 32'd0);
        tick(); check("cont_first_wr", {31'b0, fifo_wr_en}, 32'd1);
        check("cont_first_data", {24'b0, fifo_wr_data}, 32'd0);
        repeat (257) tick();

        // wr_rst_busy pulse of 3 cycles
        wr_rst_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("rstbusy_hold", {31'b0, fifo_wr_en}, 32'd0);
        end
        wr_rst_busy = 1'b0;
        push_n(4);
        tick(); check("rstbusy_resume", {31'b0, fifo_wr_en}, 32'd1);
        repeat (3) tick();
        enable = 1'b0;
        tick();
        check("cont_stop_wr", {31'b0, fifo_wr_en}, 32'd0);
        check("cont_stop_busy", {31'b0, busy}, 32'd0);
        check("cont_no_done", {31'b0, burst_done}, 32'd0);
        check("cont_drain", sb.size(), 32'd0);

        // REFILL
        mode = 2'b10; enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(); check("refill_idle", {31'b0, busy}, 32'd0);
        end
        empty = 1'b1;
        tick(); empty = 1'b0; check("refill_lat1", {31'b0, fifo_wr_en}, 32'd0);
        tick(); check("refill_lat2", {31'b0, fifo_wr_en}, 32'd0);
        push_n(3);
        tick(); check("refill_start", {31'b0, fifo_wr_en}, 32'd1);
        repeat (2) tick();
        almost_full = 1'b1;
        tick();
        check("refill_af_stop", {31'b0, fifo_wr_en}, 32'd0);
        check("refill_wait_busy", {31'b0, busy}, 32'd1);
        almost_full = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(); check("refill_wait_empty", {31'b0, fifo_wr_en}, 32'd0);
        end
        empty = 1'b1;
        tick(); empty = 1'b0;
        tick();
        tick(); check("refill_resume_lat", {31'b0, fifo_wr_en}, 32'd0);
        push_n(1);
        tick(); check("refill_restart", {31'b0, fifo_wr_en}, 32'd1);
        almost_full = 1'b1;
        tick(); check("refill_af_stop2", {31'b0, fifo_wr_en}, 32'd0);
        // almost_full and empty together: almost_full wins
        empty = 1'b1;
        tick(); empty = 1'b0;
        tick();
        tick();
        check("af_wins_wr", {31'b0, fifo_wr_en}, 32'd0);
        check("af_wins_busy", {31'b0, busy}, 32'd1);
        tick(); check("af_wins_wr2", {31'b0, fifo_wr_en}, 32'd0);
        enable = 1'b0;
        tick(); check("refill_abort_idle", {31'b0, busy}, 32'd0);
        almost_full = 1'b0;
        check("refill_drain", sb.size(), 32'd0);

        // BURST of 4 with a second start mid-burst
        mode = 2'b11; enable = 1'b1;
        tick();
        push_n(4);
        start = 1'b1;
        tick(); start = 1'b0;
        check("burst_first_wr", {31'b0, fifo_wr_en}, 32'd1);
        check("burst_busy", {31'b0, busy}, 32'd1);
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        tick();
        check("burst_4th_wr", {31'b0, fifo_wr_en}, 32'd1);
        check("burst_4th_done", {31'b0, burst_done}, 32'd0);
        check("burst_end_busy", {31'b0, busy}, 32'd0);
        tick();
        check("burst_done_pulse", {31'b0, burst_done}, 32'd1);
        check("burst_no_5th", {31'b0, fifo_wr_en}, 32'd0);
        tick();
        check("burst_done_clear", {31'b0, burst_done}, 32'd0);
        check("burst_drain", sb.size(), 32'd0);

        // reset mid-burst at word 2
        push_n(2);
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); check("mid_word2", {31'b0, fifo_wr_en}, 32'd1);
        #6;
        rst = 1'b0;
        #1;
        check("async_wr_en", {31'b0, fifo_wr_en}, 32'd0);
        check("async_data", {24'b0, fifo_wr_data}, 32'd0);
        check("async_busy", {31'b0, busy}, 32'd0);
        check("async_done", {31'b0, burst_done}, 32'd0);
        check("mid_drain", sb.size(), 32'd0);
        exp_d = 8'd0;
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_no_done", {31'b0, burst_done}, 32'd0);
            check("post_rst_no_wr", {31'b0, fifo_wr_en}, 32'd0);
        end

`ifdef FIFO_WR_GEN_ERR_EN
        // sticky overflow flag
        rst = 1'b0; mode = 2'b01; enable = 1'b1;
        tick(); check("ovf_rst", {31'b0, ovf_err}, 32'd0);
        push_n(2);
        rst = 1'b1;
        tick();
        tick(); check("ovf_wr", {31'b0, fifo_wr_en}, 32'd1);
        full = 1'b1;
        tick(); full = 1'b0; enable = 1'b0;
        check("ovf_set", {31'b0, ovf_err}, 32'd1);
        repeat (2) tick();
        check("ovf_sticky", {31'b0, ovf_err}, 32'd1);
        rst = 1'b0;
        #1;
        check("ovf_clear", {31'b0, ovf_err}, 32'd0);
        check("ovf_drain", sb.size(), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
